// File: rtl/pipe_scroller_if.sv
// Pipe-pattern interface between the scroller (consumer) and the pattern
// generator / game environment. The slave modport is the scroller side.
interface pipe_scroller_if;
    logic        Button;
    logic [15:0] Pattern1;
    logic [15:0] Pattern2;
    logic [15:0] BirdY;
    logic [15:0] PipesPosition1;
    logic [15:0] PipesPosition2;
    logic [15:0] GapTop1;
    logic [15:0] GapTop2;
    logic [15:0] Score;
    logic        Running;
    logic        GameOver;

    modport master (
        output Button, Pattern1, Pattern2, BirdY,
        input  PipesPosition1, PipesPosition2, GapTop1, GapTop2,
               Score, Running, GameOver
    );

    modport slave (
        input  Button, Pattern1, Pattern2, BirdY,
        output PipesPosition1, PipesPosition2, GapTop1, GapTop2,
               Score, Running, GameOver
    );
endinterface

// File: rtl/pipe_scroller.sv
// pipe_scroller: scrolls two pipes leftward, latches their gap heights from
// the pattern generator at each respawn, detects bird/pipe collisions, counts
// the score and owns the IDLE/RUN/OVER game state.
// Optional feature macro: PIPE_SPEEDUP_EN -- scroll step grows with the score
// (STEP_PX + min(Score/SPEEDUP_EVERY, 3)). Undefined: constant STEP_PX step.
module pipe_scroller #(
    parameter int unsigned STEP_DIV     = 131072,
    parameter int unsigned SCREEN_W     = 640,
    parameter int unsigned PIPE_SPACING = 320,
    parameter int unsigned PIPE_W       = 60,
    parameter int unsigned GAP_H        = 120,
    parameter int unsigned BIRD_X       = 160,
    parameter int unsigned BIRD_W       = 34,
    parameter int unsigned BIRD_H       = 24,
    parameter int unsigned STEP_PX      = 1
`ifdef PIPE_SPEEDUP_EN
    ,
    parameter int unsigned SPEEDUP_EVERY = 10
`endif
) (
    input  logic           clk,
    input  logic           Reset,
    pipe_scroller_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    localparam int unsigned PRESC_W = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(STEP_DIV - 1);
    localparam logic [PRESC_W-1:0] PRESC_ONE  = PRESC_W'(1);

    localparam logic [15:0] INIT_POS1   = 16'(SCREEN_W);
    localparam logic [15:0] INIT_POS2   = 16'(SCREEN_W + PIPE_SPACING);
    localparam logic [15:0] RELOAD_BASE = 16'(2 * PIPE_SPACING);

    localparam logic [16:0] PIPE_W17 = 17'(PIPE_W);
    localparam logic [16:0] GAP_H17  = 17'(GAP_H);
    localparam logic [16:0] BIRD_X17 = 17'(BIRD_X);
    localparam logic [16:0] BIRD_W17 = 17'(BIRD_W);
    localparam logic [16:0] BIRD_H17 = 17'(BIRD_H);

    // Next X of one pipe on a scroll step; zero is always visited and held for one step.
    function automatic logic [15:0] pipe_next(input logic [15:0] pos, input logic [15:0] s);
        logic [15:0] res;
        if (pos == 16'd0) begin
            res = RELOAD_BASE - s;
        end else if (pos <= s) begin
            res = 16'd0;
        end else begin
            res = pos - s;
        end
        return res;
    endfunction

    // Right edge of the pipe moves from the bird's right side to at-or-left of its left edge.
    function automatic logic pipe_cross(input logic [15:0] old_pos, input logic [15:0] new_pos);
        logic old_right;
        logic new_left;
        old_right = ({1'b0, old_pos} + PIPE_W17) > BIRD_X17;
        new_left  = ({1'b0, new_pos} + PIPE_W17) <= BIRD_X17;
        return old_right && new_left;
    endfunction

    // Bird box overlaps the pipe column and is not fully inside its gap.
    function automatic logic pipe_hit(input logic [15:0] pos, input logic [15:0] gap,
                                      input logic [15:0] bird_y);
        logic x_ovl;
        logic y_out;
        x_ovl = ({1'b0, pos} <= (BIRD_X17 + BIRD_W17 - 17'd1)) &&
                (({1'b0, pos} + PIPE_W17 - 17'd1) >= BIRD_X17);
        y_out = ({1'b0, bird_y} < {1'b0, gap}) ||
                (({1'b0, bird_y} + BIRD_H17) > ({1'b0, gap} + GAP_H17));
        return x_ovl && y_out;
    endfunction

    // Score plus 0..2, saturating at all-ones.
    function automatic logic [15:0] score_add(input logic [15:0] score, input logic [1:0] inc);
        logic [16:0] sum;
        sum = {1'b0, score} + {15'd0, inc};
        if (sum[16]) begin
            return 16'hFFFF;
        end else begin
            return sum[15:0];
        end
    endfunction

    state_t             state_q, state_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [15:0]        pos1_q, pos1_d;
    logic [15:0]        pos2_q, pos2_d;
    logic [15:0]        gap1_q, gap1_d;
    logic [15:0]        gap2_q, gap2_d;
    logic [15:0]        score_q, score_d;
    logic               running_q, running_d;
    logic               over_q, over_d;

    logic [15:0]        step_sz_s;
    logic               step_s;
    logic               coll_s;
    logic [15:0]        pos1_nx_s;
    logic [15:0]        pos2_nx_s;
    logic [1:0]         cross_cnt_s;
    logic [15:0]        score_inc_s;

`ifdef PIPE_SPEEDUP_EN
    logic [15:0] speed_lvl_s;

    // Step size grows by one pixel per SPEEDUP_EVERY points, capped at +3.
    always_comb begin
        speed_lvl_s = score_q / 16'(SPEEDUP_EVERY);
        if (speed_lvl_s > 16'd3) begin
            step_sz_s = 16'(STEP_PX) + 16'd3;
        end else begin
            step_sz_s = 16'(STEP_PX) + speed_lvl_s;
        end
    end
`else
    assign step_sz_s = 16'(STEP_PX);
`endif

    // Step strobe, collision and per-step datapath candidates.
    always_comb begin
        step_s      = (state_q == ST_RUN) && (presc_q == PRESC_LAST);
        coll_s      = (state_q == ST_RUN) &&
                      (pipe_hit(pos1_q, gap1_q, bus.BirdY) || pipe_hit(pos2_q, gap2_q, bus.BirdY));
        pos1_nx_s   = pipe_next(pos1_q, step_sz_s);
        pos2_nx_s   = pipe_next(pos2_q, step_sz_s);
        cross_cnt_s = {1'b0, pipe_cross(pos1_q, pos1_nx_s)} +
                      {1'b0, pipe_cross(pos2_q, pos2_nx_s)};
        score_inc_s = score_add(score_q, cross_cnt_s);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; Button is only looked at in IDLE and OVER.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!bus.Button) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (coll_s) begin
                    state_d = ST_OVER;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_OVER: begin
                if (bus.Button) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_OVER;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM output logic: next values of pipes, gaps, score, prescaler and flags.
    always_comb begin
        presc_d   = '0;
        pos1_d    = pos1_q;
        pos2_d    = pos2_q;
        gap1_d    = gap1_q;
        gap2_d    = gap2_q;
        score_d   = score_q;
        case (state_q)
            ST_IDLE: begin
                pos1_d = INIT_POS1;
                pos2_d = INIT_POS2;
                if (!bus.Button) begin
                    gap1_d  = bus.Pattern1;
                    gap2_d  = bus.Pattern2;
                    score_d = 16'd0;
                end else begin
                    score_d = score_q;
                end
            end
            ST_RUN: begin
                if (step_s) begin
                    presc_d = '0;
                    pos1_d  = pos1_nx_s;
                    pos2_d  = pos2_nx_s;
                    // A respawning pipe takes its new gap from the generator.
                    if (pos1_q == 16'd0) begin
                        gap1_d = bus.Pattern1;
                    end else begin
                        gap1_d = gap1_q;
                    end
                    if (pos2_q == 16'd0) begin
                        gap2_d = bus.Pattern2;
                    end else begin
                        gap2_d = gap2_q;
                    end
                    // No points for a step that coincides with a crash.
                    if (coll_s) begin
                        score_d = score_q;
                    end else begin
                        score_d = score_inc_s;
                    end
                end else begin
                    presc_d = presc_q + PRESC_ONE;
                end
            end
            ST_OVER: begin
                if (bus.Button) begin
                    pos1_d = INIT_POS1;
                    pos2_d = INIT_POS2;
                end else begin
                    pos1_d = pos1_q;
                    pos2_d = pos2_q;
                end
            end
            default: begin
                pos1_d = INIT_POS1;
                pos2_d = INIT_POS2;
            end
        endcase
        running_d = (state_d == ST_RUN);
        over_d    = (state_d == ST_OVER);
    end

    // Datapath and output flag registers.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            presc_q   <= '0;
            pos1_q    <= INIT_POS1;
            pos2_q    <= INIT_POS2;
            gap1_q    <= 16'd0;
            gap2_q    <= 16'd0;
            score_q   <= 16'd0;
            running_q <= 1'b0;
            over_q    <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            pos1_q    <= pos1_d;
            pos2_q    <= pos2_d;
            gap1_q    <= gap1_d;
            gap2_q    <= gap2_d;
            score_q   <= score_d;
            running_q <= running_d;
            over_q    <= over_d;
        end
    end

    assign bus.PipesPosition1 = pos1_q;
    assign bus.PipesPosition2 = pos2_q;
    assign bus.GapTop1        = gap1_q;
    assign bus.GapTop2        = gap2_q;
    assign bus.Score          = score_q;
    assign bus.Running        = running_q;
    assign bus.GameOver       = over_q;

endmodule

// File: tb/tb_pipe_scroller.sv
// Directed bench for pipe_scroller with a small geometry: STEP_DIV=4,
// SCREEN_W=64, PIPE_SPACING=32, PIPE_W=8, GAP_H=20, BIRD_X=16, BIRD_W=4,
// BIRD_H=4, STEP_PX=1. A table walks one full game from start to crash.
module tb_pipe_scroller;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    always #5 clk = ~clk;

    pipe_scroller_if bus ();

    pipe_scroller #(
        .STEP_DIV     (4),
        .SCREEN_W     (64),
        .PIPE_SPACING (32),
        .PIPE_W       (8),
        .GAP_H        (20),
        .BIRD_X       (16),
        .BIRD_W       (4),
        .BIRD_H       (4),
        .STEP_PX      (1)
    ) dut (
        .clk   (clk),
        .Reset (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int          cyc;
        logic [15:0] pat1;
        logic [15:0] pos1;
        logic [15:0] pos2;
        logic [15:0] gap1;
        logic [15:0] score;
        logic        run;
        logic        over;
    } vec_t;

    vec_t vecs [16];

    task automatic tick();
        @(posedge clk);
        #1;
        cyc = cyc + 1;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s at cyc %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [15:0] p1, input logic [15:0] p2,
                           input logic [15:0] g1, input logic [15:0] sc,
                           input logic r, input logic o);
        chk({tag, ".pos1"},  bus.PipesPosition1, p1);
        chk({tag, ".pos2"},  bus.PipesPosition2, p2);
        chk({tag, ".gap1"},  bus.GapTop1, g1);
        chk({tag, ".score"}, bus.Score, sc);
        chk({tag, ".run"},   {15'd0, bus.Running}, {15'd0, r});
        chk({tag, ".over"},  {15'd0, bus.GameOver}, {15'd0, o});
    endtask

    initial begin
        // cyc counts clock edges after the start edge; a step lands every 4th edge.
        vecs[0]  = '{0,   16'd30, 16'd64, 16'd96, 16'd30, 16'd0, 1'b1, 1'b0};
        vecs[1]  = '{3,   16'd30, 16'd64, 16'd96, 16'd30, 16'd0, 1'b1, 1'b0};
        vecs[2]  = '{4,   16'd30, 16'd63, 16'd95, 16'd30, 16'd0, 1'b1, 1'b0};
        vecs[3]  = '{16,  16'd30, 16'd60, 16'd92, 16'd30, 16'd0, 1'b1, 1'b0};
        vecs[4]  = '{223, 16'd30, 16'd9,  16'd41, 16'd30, 16'd0, 1'b1, 1'b0};
        vecs[5]  = '{224, 16'd30, 16'd8,  16'd40, 16'd30, 16'd1, 1'b1, 1'b0};
        vecs[6]  = '{256, 16'd50, 16'd0,  16'd32, 16'd30, 16'd1, 1'b1, 1'b0};
        vecs[7]  = '{259, 16'd50, 16'd0,  16'd32, 16'd30, 16'd1, 1'b1, 1'b0};
        vecs[8]  = '{260, 16'd50, 16'd63, 16'd31, 16'd50, 16'd1, 1'b1, 1'b0};
        vecs[9]  = '{352, 16'd50, 16'd40, 16'd8,  16'd50, 16'd2, 1'b1, 1'b0};
        vecs[10] = '{384, 16'd50, 16'd32, 16'd0,  16'd50, 16'd2, 1'b1, 1'b0};
        vecs[11] = '{388, 16'd50, 16'd31, 16'd63, 16'd50, 16'd2, 1'b1, 1'b0};
        vecs[12] = '{435, 16'd50, 16'd20, 16'd52, 16'd50, 16'd2, 1'b1, 1'b0};
        vecs[13] = '{436, 16'd50, 16'd19, 16'd51, 16'd50, 16'd2, 1'b1, 1'b0};
        vecs[14] = '{437, 16'd50, 16'd19, 16'd51, 16'd50, 16'd2, 1'b0, 1'b1};
        vecs[15] = '{460, 16'd50, 16'd19, 16'd51, 16'd50, 16'd2, 1'b0, 1'b1};

        rst_n        = 1'b0;
        bus.Button   = 1'b1;
        bus.Pattern1 = 16'd30;
        bus.Pattern2 = 16'd32;
        bus.BirdY    = 16'd35;
        #12;
        chk_all("reset", 16'd64, 16'd96, 16'd0, 16'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();
        tick();
        chk_all("idle", 16'd64, 16'd96, 16'd0, 16'd0, 1'b0, 1'b0);

        // Start; Button stays low through RUN so OVER is held once reached.
        bus.Button = 1'b0;
        tick();
        cyc = 0;
        for (int i = 0; i < 16; i++) begin
            bus.Pattern1 = vecs[i].pat1;
            while (cyc < vecs[i].cyc) begin
                tick();
            end
            chk_all($sformatf("vec%0d", i), vecs[i].pos1, vecs[i].pos2, vecs[i].gap1,
                    vecs[i].score, vecs[i].run, vecs[i].over);
        end

        // Release in OVER returns to IDLE with positions restored, score kept.
        bus.Button = 1'b1;
        tick();
        chk_all("to_idle", 16'd64, 16'd96, 16'd50, 16'd2, 1'b0, 1'b0);

        // Restart clears the score; Button high during RUN has no effect.
        bus.Button   = 1'b0;
        bus.Pattern1 = 16'd44;
        tick();
        chk_all("restart", 16'd64, 16'd96, 16'd44, 16'd0, 1'b1, 1'b0);
        bus.Button = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
        end
        chk_all("btn_ign1", 16'd63, 16'd95, 16'd44, 16'd0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
        end
        chk_all("btn_ign2", 16'd62, 16'd94, 16'd44, 16'd0, 1'b1, 1'b0);

        // Asynchronous reset between clock edges takes effect immediately.
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", 16'd64, 16'd96, 16'd0, 16'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();
        chk_all("post_rst", 16'd64, 16'd96, 16'd0, 16'd0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
